// File: rtl/cam_pkg.sv
// Shared types and constants for the colour-threshold capture path.
// Optional smoothing of published boxes is built when BBOX_SMOOTH_EN is defined.
package cam_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned SUM_W   = COORD_W + 1;

  localparam logic [COORD_W-1:0] BBOX_EMPTY_MIN = 10'd641;
  localparam logic [COORD_W-1:0] BBOX_EMPTY_MAX = 10'd0;

  typedef enum logic [1:0] {
    S_WAIT_CFG,
    S_WARMUP,
    S_RUN
  } ctrl_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_y;
  } bbox_t;

  // Mean of two coordinates: full-width sum, then drop the LSB.
  function automatic logic [COORD_W-1:0] avg_coord(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    return sum[SUM_W-1:1];
  endfunction

  function automatic bbox_t bbox_avg(input bbox_t a, input bbox_t b);
    bbox_t r;
    r.min_x = avg_coord(a.min_x, b.min_x);
    r.max_x = avg_coord(a.max_x, b.max_x);
    r.min_y = avg_coord(a.min_y, b.min_y);
    r.max_y = avg_coord(a.max_y, b.max_y);
    return r;
  endfunction

endpackage

// File: rtl/cam_bbox_qualify.sv
// Combinational bounding-box qualification: ordered bounds and minimum size.
module cam_bbox_qualify
  import cam_pkg::*;
#(
  parameter int unsigned MIN_W = 4,
  parameter int unsigned MIN_H = 4
) (
  input  bbox_t box,
  output logic  found
);

  logic [SUM_W-1:0] width;
  logic [SUM_W-1:0] height;

  // Sizes are only meaningful when the bounds are ordered; the ordering terms gate them.
  always_comb begin
    width  = SUM_W'(box.max_x) - SUM_W'(box.min_x) + SUM_W'(1);
    height = SUM_W'(box.max_y) - SUM_W'(box.min_y) + SUM_W'(1);
    found  = (box.min_x <= box.max_x) && (box.min_y <= box.max_y) &&
             (width >= SUM_W'(MIN_W)) && (height >= SUM_W'(MIN_H));
  end

endmodule

// File: rtl/cam_bbox_frame_ctrl.sv
// Frame-level sequencer: config/warm-up gating, per-frame bbox latch, valid/ack result port.
// Define BBOX_SMOOTH_EN to average consecutive found boxes before publishing.
module cam_bbox_frame_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned WARMUP_FRAMES = 2,
  parameter int unsigned MIN_W         = 4,
  parameter int unsigned MIN_H         = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic               config_done,
  input  logic               vsync,
  input  logic [COORD_W-1:0] cap_min_x,
  input  logic [COORD_W-1:0] cap_max_x,
  input  logic [COORD_W-1:0] cap_min_y,
  input  logic [COORD_W-1:0] cap_max_y,
  output logic               capture_en,
  output logic               res_valid,
  input  logic               res_ack,
  output logic               res_found,
  output logic [COORD_W-1:0] res_min_x,
  output logic [COORD_W-1:0] res_max_x,
  output logic [COORD_W-1:0] res_min_y,
  output logic [COORD_W-1:0] res_max_y,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int unsigned WARM_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES + 1) : 1;

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  logic              vsync_d;
  logic              fe;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;
  logic              skip_done;
  logic              latch;
  logic              ack_take;
  bbox_t             cap_box;
  bbox_t             pub_box;
  logic              cap_found;

  assign fe        = vsync & ~vsync_d;
  assign warm_done = (warm_cnt == WARM_W'(WARMUP_FRAMES));
  assign latch     = (state == S_RUN) && fe && skip_done && config_done;
  assign ack_take  = res_valid & res_ack;

  assign cap_box.min_x = cap_min_x;
  assign cap_box.max_x = cap_max_x;
  assign cap_box.min_y = cap_min_y;
  assign cap_box.max_y = cap_max_y;

  cam_bbox_qualify #(
    .MIN_W (MIN_W),
    .MIN_H (MIN_H)
  ) u_qualify (
    .box   (cap_box),
    .found (cap_found)
  );

`ifdef BBOX_SMOOTH_EN
  bbox_t sm_box;
  logic  sm_valid;

  // Smoothing history tracks the last published found box; not-found frames leave it alone.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      sm_box   <= '0;
      sm_valid <= 1'b0;
    end else if (!config_done) begin
      sm_box   <= '0;
      sm_valid <= 1'b0;
    end else if (latch && cap_found) begin
      sm_box   <= pub_box;
      sm_valid <= 1'b1;
    end
  end

  assign pub_box = (cap_found && sm_valid) ? bbox_avg(sm_box, cap_box) : cap_box;
`else
  assign pub_box = cap_box;
`endif

  // Next-state logic; dropping config_done overrides every state.
  always_comb begin
    state_next = state;
    unique case (state)
      S_WAIT_CFG: if (config_done) state_next = S_WARMUP;
      S_WARMUP:   if (warm_done) state_next = S_RUN;
      S_RUN:      state_next = S_RUN;
      default:    state_next = S_WAIT_CFG;
    endcase
    if (!config_done) state_next = S_WAIT_CFG;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state      <= S_WAIT_CFG;
      capture_en <= 1'b0;
      vsync_d    <= 1'b0;
      warm_cnt   <= '0;
      skip_done  <= 1'b0;
    end else begin
      state      <= state_next;
      capture_en <= (state_next != S_WAIT_CFG);
      vsync_d    <= vsync;
      if (state != S_WARMUP || !config_done)
        warm_cnt <= '0;
      else if (fe && !warm_done)
        warm_cnt <= warm_cnt + WARM_W'(1);
      // First frame edge in S_RUN closes a possibly partial frame and is discarded.
      if (state != S_RUN || !config_done)
        skip_done <= 1'b0;
      else if (fe)
        skip_done <= 1'b1;
    end
  end

  // Result registers and statistics; a latch takes priority over a same-edge ack.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_found <= 1'b0;
      res_min_x <= '0;
      res_max_x <= '0;
      res_min_y <= '0;
      res_max_y <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else if (!config_done) begin
      res_valid <= 1'b0;
      frame_cnt <= '0;
    end else if (latch) begin
      res_valid <= 1'b1;
      res_found <= cap_found;
      res_min_x <= pub_box.min_x;
      res_max_x <= pub_box.max_x;
      res_min_y <= pub_box.min_y;
      res_max_y <= pub_box.max_y;
      frame_cnt <= frame_cnt + CNT_W'(1);
      if (res_valid && !res_ack && (drop_cnt != '1))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end else if (ack_take) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_bbox_frame_ctrl.sv
// Directed self-checking bench for cam_bbox_frame_ctrl (WARMUP_FRAMES=2, MIN_W=MIN_H=4).
module tb_cam_bbox_frame_ctrl;

  localparam int unsigned CNT_W = 16;

`ifdef BBOX_SMOOTH_EN
  localparam int unsigned EXP_DROP_MINX = 60;
  localparam int unsigned EXP_ACK_MINX  = 30;
`else
  localparam int unsigned EXP_DROP_MINX = 20;
  localparam int unsigned EXP_ACK_MINX  = 1;
`endif

  logic             pclk = 1'b0;
  logic             reset;
  logic             config_done;
  logic             vsync;
  logic [9:0]       cap_min_x, cap_max_x, cap_min_y, cap_max_y;
  logic             capture_en;
  logic             res_valid;
  logic             res_ack;
  logic             res_found;
  logic [9:0]       res_min_x, res_max_x, res_min_y, res_max_y;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  cam_bbox_frame_ctrl #(
    .WARMUP_FRAMES (2),
    .MIN_W         (4),
    .MIN_H         (4),
    .CNT_W         (CNT_W)
  ) dut (
    .pclk        (pclk),
    .reset       (reset),
    .config_done (config_done),
    .vsync       (vsync),
    .cap_min_x   (cap_min_x),
    .cap_max_x   (cap_max_x),
    .cap_min_y   (cap_min_y),
    .cap_max_y   (cap_max_y),
    .capture_en  (capture_en),
    .res_valid   (res_valid),
    .res_ack     (res_ack),
    .res_found   (res_found),
    .res_min_x   (res_min_x),
    .res_max_x   (res_max_x),
    .res_min_y   (res_min_y),
    .res_max_y   (res_max_y),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_box(input int unsigned a, input int unsigned b,
                         input int unsigned c, input int unsigned d);
    cap_min_x = 10'(a);
    cap_max_x = 10'(b);
    cap_min_y = 10'(c);
    cap_max_y = 10'(d);
  endtask

  // One frame: vsync high two cycles then low two; ack optionally on the edge edge itself.
  task automatic pulse(input int unsigned a, input int unsigned b, input int unsigned c,
                       input int unsigned d, input logic ack);
    set_box(a, b, c, d);
    vsync   = 1'b1;
    res_ack = ack;
    step();
    res_ack = 1'b0;
    step();
    vsync = 1'b0;
    step();
    step();
  endtask

  task automatic glitch();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  initial begin
    reset       = 1'b1;
    config_done = 1'b0;
    vsync       = 1'b0;
    res_ack     = 1'b0;
    set_box(0, 0, 0, 0);
    step();
    step();
    check("rst_capture_en", 32'(capture_en), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_found", 32'(res_found), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    reset = 1'b0;
    step();
    check("wait_cfg_capture_en", 32'(capture_en), 0);

    config_done = 1'b1;
    step();
    check("armed_capture_en", 32'(capture_en), 1);

    pulse(100, 200, 50, 120, 1'b0);
    check("warm1_res_valid", 32'(res_valid), 0);
    pulse(100, 200, 50, 120, 1'b0);
    check("warm2_res_valid", 32'(res_valid), 0);
    pulse(100, 200, 50, 120, 1'b0);
    check("skip_res_valid", 32'(res_valid), 0);
    check("skip_frame_cnt", 32'(frame_cnt), 0);

    pulse(100, 200, 50, 120, 1'b0);
    check("f1_res_valid", 32'(res_valid), 1);
    check("f1_res_found", 32'(res_found), 1);
    check("f1_min_x", 32'(res_min_x), 100);
    check("f1_max_x", 32'(res_max_x), 200);
    check("f1_min_y", 32'(res_min_y), 50);
    check("f1_max_y", 32'(res_max_y), 120);
    check("f1_frame_cnt", 32'(frame_cnt), 1);

    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    check("ack_res_valid", 32'(res_valid), 0);
    step();
    check("ack_hold_min_x", 32'(res_min_x), 100);

    pulse(641, 0, 641, 0, 1'b0);
    check("empty_res_valid", 32'(res_valid), 1);
    check("empty_res_found", 32'(res_found), 0);
    check("empty_min_x", 32'(res_min_x), 641);
    check("empty_frame_cnt", 32'(frame_cnt), 2);
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;

    pulse(10, 12, 10, 40, 1'b0);
    check("narrow_res_found", 32'(res_found), 0);
    check("narrow_max_y", 32'(res_max_y), 40);
    check("narrow_drop_cnt", 32'(drop_cnt), 0);

    pulse(20, 30, 20, 30, 1'b0);
    check("drop_res_valid", 32'(res_valid), 1);
    check("drop_res_found", 32'(res_found), 1);
    check("drop_min_x", 32'(res_min_x), EXP_DROP_MINX);
    check("drop_drop_cnt", 32'(drop_cnt), 1);
    check("drop_frame_cnt", 32'(frame_cnt), 4);

    pulse(1, 9, 1, 9, 1'b1);
    check("latch_ack_res_valid", 32'(res_valid), 1);
    check("latch_ack_min_x", 32'(res_min_x), EXP_ACK_MINX);
    check("latch_ack_drop_cnt", 32'(drop_cnt), 1);
    check("latch_ack_frame_cnt", 32'(frame_cnt), 5);

    set_box(1, 9, 1, 9);
    vsync = 1'b1;
    for (int i = 0; i < 10; i++) step();
    vsync = 1'b0;
    step();
    check("long_vsync_frame_cnt", 32'(frame_cnt), 6);
    check("long_vsync_drop_cnt", 32'(drop_cnt), 2);

    config_done = 1'b0;
    step();
    check("cfg_drop_capture_en", 32'(capture_en), 0);
    check("cfg_drop_res_valid", 32'(res_valid), 0);
    check("cfg_drop_frame_cnt", 32'(frame_cnt), 0);
    check("cfg_drop_drop_cnt", 32'(drop_cnt), 2);

    config_done = 1'b1;
    step();
    set_box(100, 200, 50, 120);
    glitch();
    glitch();
    glitch();
    check("rearm_skip_res_valid", 32'(res_valid), 0);
    glitch();
    check("rearm_res_valid", 32'(res_valid), 1);
    check("rearm_frame_cnt", 32'(frame_cnt), 1);
    check("rearm_min_x", 32'(res_min_x), 100);
    check("rearm_capture_en", 32'(capture_en), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
